// File: rtl/topk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : topk_pkg
//  Description : Shared widths, rank-entry type and value compare for the
//                streaming top-K tracker. Define TOPK_SIGNED_EN to compare
//                values as two's-complement numbers instead of unsigned.
//  Revision    : 1.0 - initial release
// ============================================================================
package topk_pkg;

  localparam int TOPK_DATA_W = 32;
  localparam int TOPK_IDX_W  = 16;
  localparam int TOPK_CNT_W  = 32;
  // Widest value the compare helper accepts; callers zero-extend into it.
  localparam int TOPK_MAX_W  = 64;

`ifdef TOPK_SIGNED_EN
  localparam logic TOPK_SIGNED = 1'b1;
`else
  localparam logic TOPK_SIGNED = 1'b0;
`endif

  // One rank of the working array at the default widths.
  typedef struct packed {
    logic [TOPK_DATA_W-1:0] value;
    logic [TOPK_IDX_W-1:0]  index;
    logic                   valid;
  } topk_entry_t;

  // a >= b for two zero-extended w-bit values. Signed ordering is obtained by
  // flipping the w-bit sign position of both operands, which maps two's
  // complement order onto plain unsigned order.
  function automatic logic topk_ge(input logic [TOPK_MAX_W-1:0] a,
                                   input logic [TOPK_MAX_W-1:0] b,
                                   input int unsigned           w);
    logic [TOPK_MAX_W-1:0] w_msb;
    w_msb = {{(TOPK_MAX_W-1){1'b0}}, TOPK_SIGNED} << (w - 1);
    return (a ^ w_msb) >= (b ^ w_msb);
  endfunction

endpackage : topk_pkg
`default_nettype wire

// File: rtl/topk_slot.sv
`default_nettype none
// ============================================================================
//  Module      : topk_slot
//  Description : One rank register of the top-K working array. Raises o_ge
//                when it holds a valid value >= the incoming sample, and picks
//                hold / shift-in from rank r-1 / load sample from its own flag
//                and the flag of the rank above it. Compare signedness follows
//                TOPK_SIGNED_EN through topk_pkg.
//  Revision    : 1.0 - initial release
// ============================================================================
module topk_slot
  import topk_pkg::*;
#(
  parameter int DATA_W = TOPK_DATA_W,
  parameter int IDX_W  = TOPK_IDX_W,
  parameter int RANK   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic              i_clear,
  input  logic              i_last,
  input  logic [DATA_W-1:0] i_stream,
  input  logic [IDX_W-1:0]  i_index,
  input  logic              i_prev_ge,
  input  logic [DATA_W-1:0] i_prev_value,
  input  logic [IDX_W-1:0]  i_prev_index,
  input  logic              i_prev_valid,
  output logic              o_ge,
  output logic [DATA_W-1:0] o_value,
  output logic [IDX_W-1:0]  o_index,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_nxt_value,
  output logic [IDX_W-1:0]  o_nxt_index,
  output logic              o_nxt_valid
);

  logic [DATA_W-1:0] r_value;
  logic [IDX_W-1:0]  r_index;
  logic              r_valid;

  logic [DATA_W-1:0] w_nxt_value;
  logic [IDX_W-1:0]  w_nxt_index;
  logic              w_nxt_valid;

  // Invalid ranks never claim >=, so the flags form a run of ones from rank 0
  // whose length is the insertion point.
  assign o_ge = r_valid &&
                topk_ge(TOPK_MAX_W'(r_value), TOPK_MAX_W'(i_stream), DATA_W);

  // Next-state select: clear empties (rank 0 may still take a same-cycle
  // sample); otherwise the first rank below the >= run loads the sample and
  // every rank further down takes its upper neighbour's entry.
  always_comb begin
    w_nxt_value = r_value;
    w_nxt_index = r_index;
    w_nxt_valid = r_valid;
    if (i_clear) begin
      w_nxt_value = '0;
      w_nxt_index = '0;
      w_nxt_valid = 1'b0;
      if (i_enable && (RANK == 0)) begin
        w_nxt_value = i_stream;
        w_nxt_index = i_index;
        w_nxt_valid = 1'b1;
      end
    end else if (i_enable && !o_ge) begin
      if (i_prev_ge) begin
        w_nxt_value = i_stream;
        w_nxt_index = i_index;
        w_nxt_valid = 1'b1;
      end else begin
        w_nxt_value = i_prev_value;
        w_nxt_index = i_prev_index;
        w_nxt_valid = i_prev_valid;
      end
    end
  end

  // Rank register; end of frame empties it after the top has snapshotted.
  always_ff @(posedge clk) begin
    if (rst || i_last) begin
      r_value <= '0;
      r_index <= '0;
      r_valid <= 1'b0;
    end else begin
      r_value <= w_nxt_value;
      r_index <= w_nxt_index;
      r_valid <= w_nxt_valid;
    end
  end

  assign o_value     = r_value;
  assign o_index     = r_index;
  assign o_valid     = r_valid;
  assign o_nxt_value = w_nxt_value;
  assign o_nxt_index = w_nxt_index;
  assign o_nxt_valid = w_nxt_valid;

endmodule : topk_slot
`default_nettype wire

// File: rtl/topk_val.sv
`default_nettype none
// ============================================================================
//  Module      : topk_val
//  Description : Streaming top-K tracker on the accumulator output stream.
//                Keeps the K largest samples of a frame sorted descending
//                with their row indices, and on last publishes a registered
//                snapshot, the frame sample count and a one-cycle done pulse.
//                Define TOPK_SIGNED_EN for two's-complement value compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module topk_val
  import topk_pkg::*;
#(
  parameter int K      = 4,
  parameter int DATA_W = TOPK_DATA_W,
  parameter int IDX_W  = TOPK_IDX_W,
  parameter int CNT_W  = TOPK_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [DATA_W-1:0]   stream,
  input  logic [IDX_W-1:0]    index,
  input  logic                clear,
  input  logic                last,
  output logic [K*DATA_W-1:0] topk_value,
  output logic [K*IDX_W-1:0]  topk_index,
  output logic [K-1:0]        topk_valid,
  output logic [CNT_W-1:0]    sample_count,
  output logic                done
);

  // Per-rank current and next-state views of the working array.
  logic              w_ge        [K];
  logic [DATA_W-1:0] w_val       [K];
  logic [IDX_W-1:0]  w_idx       [K];
  logic              w_vld       [K];
  logic              w_prev_ge   [K];
  logic [DATA_W-1:0] w_prev_val  [K];
  logic [IDX_W-1:0]  w_prev_idx  [K];
  logic              w_prev_vld  [K];
  logic [DATA_W-1:0] w_nxt_val   [K];
  logic [IDX_W-1:0]  w_nxt_idx   [K];
  logic              w_nxt_vld   [K];

  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [CNT_W-1:0]    w_cnt_nxt;

  logic [K*DATA_W-1:0] r_topk_value;
  logic [K*IDX_W-1:0]  r_topk_index;
  logic [K-1:0]        r_topk_valid;
  logic [CNT_W-1:0]    r_sample_count;
  logic                r_done;

  generate
    for (genvar r = 0; r < K; r++) begin : g_slot
      // Rank 0 sees a virtual always->= neighbour above it.
      if (r == 0) begin : g_head
        assign w_prev_ge[r]  = 1'b1;
        assign w_prev_val[r] = '0;
        assign w_prev_idx[r] = '0;
        assign w_prev_vld[r] = 1'b0;
      end else begin : g_chain
        assign w_prev_ge[r]  = w_ge[r-1];
        assign w_prev_val[r] = w_val[r-1];
        assign w_prev_idx[r] = w_idx[r-1];
        assign w_prev_vld[r] = w_vld[r-1];
      end

      topk_slot #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .RANK   (r)
      ) u_slot (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (enable),
        .i_clear      (clear),
        .i_last       (last),
        .i_stream     (stream),
        .i_index      (index),
        .i_prev_ge    (w_prev_ge[r]),
        .i_prev_value (w_prev_val[r]),
        .i_prev_index (w_prev_idx[r]),
        .i_prev_valid (w_prev_vld[r]),
        .o_ge         (w_ge[r]),
        .o_value      (w_val[r]),
        .o_index      (w_idx[r]),
        .o_valid      (w_vld[r]),
        .o_nxt_value  (w_nxt_val[r]),
        .o_nxt_index  (w_nxt_idx[r]),
        .o_nxt_valid  (w_nxt_vld[r])
      );
    end
  endgenerate

  // Saturating increment; dropped samples still count as accepted.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  // Counter next state, with clear applied before any same-cycle sample.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clear) begin
      w_cnt_nxt = enable ? CNT_W'(1) : '0;
    end else if (enable) begin
      w_cnt_nxt = w_cnt_inc;
    end
  end

  // Working sample counter; restarts empty after each end of frame.
  always_ff @(posedge clk) begin
    if (rst || last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Snapshot of the frame's final array (including a same-cycle sample) and
  // done pulse; invalid ranks are forced to zero value and index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_topk_value   <= '0;
      r_topk_index   <= '0;
      r_topk_valid   <= '0;
      r_sample_count <= '0;
      r_done         <= 1'b0;
    end else begin
      r_done <= last;
      if (last) begin
        r_sample_count <= w_cnt_nxt;
        for (int r = 0; r < K; r++) begin
          r_topk_value[r*DATA_W +: DATA_W] <= w_nxt_vld[r] ? w_nxt_val[r] : '0;
          r_topk_index[r*IDX_W +: IDX_W]   <= w_nxt_vld[r] ? w_nxt_idx[r] : '0;
          r_topk_valid[r]                  <= w_nxt_vld[r];
        end
      end
    end
  end

  assign topk_value   = r_topk_value;
  assign topk_index   = r_topk_index;
  assign topk_valid   = r_topk_valid;
  assign sample_count = r_sample_count;
  assign done         = r_done;

endmodule : topk_val
`default_nettype wire

// File: tb/tb_topk_val.sv
`default_nettype none
// ============================================================================
//  Module      : tb_topk_val
//  Description : Self-checking bench for topk_val (K=4, DATA_W=8, IDX_W=16,
//                CNT_W=4 so counter saturation is reachable). Directed vector
//                table followed by random traffic against a reference model.
//                Honours TOPK_SIGNED_EN for the expected ordering.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_topk_val;

  localparam int K  = 4;
  localparam int DW = 8;
  localparam int IW = 16;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst, enable, clear, last;
  logic [DW-1:0]   stream;
  logic [IW-1:0]   index;
  logic [K*DW-1:0] topk_value;
  logic [K*IW-1:0] topk_index;
  logic [K-1:0]    topk_valid;
  logic [CW-1:0]   sample_count;
  logic            done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  topk_val #(.K(K), .DATA_W(DW), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .stream       (stream),
    .index        (index),
    .clear        (clear),
    .last         (last),
    .topk_value   (topk_value),
    .topk_index   (topk_index),
    .topk_valid   (topk_valid),
    .sample_count (sample_count),
    .done         (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r, e;
    logic [7:0]  s;
    logic [15:0] ix;
    logic        c, l;
    logic        k;      // compare snapshot outputs on this row
    logic        d;
    logic [31:0] ev;
    logic [63:0] ei;
    logic [3:0]  evl;
    logic [3:0]  ec;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, e, input logic [7:0] s, input logic [15:0] ix,
                     input logic c, l, k, d, input logic [31:0] ev,
                     input logic [63:0] ei, input logic [3:0] evl, ec);
    vec_t v;
    v.r = r; v.e = e; v.s = s; v.ix = ix; v.c = c; v.l = l; v.k = k; v.d = d;
    v.ev = ev; v.ei = ei; v.evl = evl; v.ec = ec;
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [7:0] v; logic [15:0] i; } smp_t;
  smp_t            fq[$];
  int              fcnt;
  logic [K*DW-1:0] m_val;
  logic [K*IW-1:0] m_idx;
  logic [K-1:0]    m_vld;
  logic [CW-1:0]   m_cnt;
  logic            m_done;

  function automatic bit mgt(input logic [7:0] a, input logic [7:0] b);
`ifdef TOPK_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Top-K of the frame: repeatedly pick the earliest strictly-largest
  // remaining sample, so equal values keep arrival order.
  task automatic snapshot();
    bit taken[];
    taken = new[fq.size()];
    m_val = '0; m_idx = '0; m_vld = '0;
    for (int r = 0; r < K; r++) begin
      int best = -1;
      for (int j = 0; j < fq.size(); j++)
        if (!taken[j] && (best < 0 || mgt(fq[j].v, fq[best].v))) best = j;
      if (best >= 0) begin
        taken[best] = 1'b1;
        m_val[r*DW +: DW] = fq[best].v;
        m_idx[r*IW +: IW] = fq[best].i;
        m_vld[r] = 1'b1;
      end
    end
    m_cnt = (fcnt > 15) ? 4'd15 : 4'(fcnt);
  endtask

  task automatic rstep(input logic r, e, input logic [7:0] s, input logic [15:0] ix,
                       input logic c, l);
    rst = r; enable = e; stream = s; index = ix; clear = c; last = l;
    @(posedge clk);
    if (r) begin
      fq.delete(); fcnt = 0;
      m_val = '0; m_idx = '0; m_vld = '0; m_cnt = '0; m_done = 1'b0;
    end else begin
      if (c) begin fq.delete(); fcnt = 0; end
      if (e) begin fq.push_back('{v: s, i: ix}); fcnt++; end
      m_done = l;
      if (l) begin snapshot(); fq.delete(); fcnt = 0; end
    end
    #1;
    chk("rnd_done",  64'(done),         64'(m_done));
    chk("rnd_value", 64'(topk_value),   64'(m_val));
    chk("rnd_index", 64'(topk_index),   64'(m_idx));
    chk("rnd_valid", 64'(topk_valid),   64'(m_vld));
    chk("rnd_count", 64'(sample_count), 64'(m_cnt));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clear = 1'b0; last = 1'b0; stream = '0; index = '0;

    // reset
    add(1,0,0,0,0,0, 1,0, 0,0,0,0);
    add(1,1,3,3,1,1, 1,0, 0,0,0,0);
    // basic frame 5,9,1,7,3 with last on the fifth
    add(0,1,5,0,0,0, 1,0, 0,0,0,0);
    add(0,1,9,1,0,0, 0,0, 0,0,0,0);
    add(0,1,1,2,0,0, 0,0, 0,0,0,0);
    add(0,1,7,3,0,0, 0,0, 0,0,0,0);
    add(0,1,3,4,0,1, 1,1, {8'd3,8'd5,8'd7,8'd9}, {16'd4,16'd0,16'd3,16'd1}, 4'b1111, 4'd5);
    add(0,0,0,0,0,0, 1,0, {8'd3,8'd5,8'd7,8'd9}, {16'd4,16'd0,16'd3,16'd1}, 4'b1111, 4'd5);
    // partial frame
    add(0,1,2,20,0,0, 0,0, 0,0,0,0);
    add(0,1,8,21,0,1, 1,1, {8'd0,8'd0,8'd2,8'd8}, {16'd0,16'd0,16'd20,16'd21}, 4'b0011, 4'd2);
    // ties, then a sample in the cycle after last starts the new frame
    add(0,1,6,10,0,0, 0,0, 0,0,0,0);
    add(0,1,6,11,0,0, 0,0, 0,0,0,0);
    add(0,1,6,12,0,1, 1,1, {8'd0,8'd6,8'd6,8'd6}, {16'd0,16'd12,16'd11,16'd10}, 4'b0111, 4'd3);
    add(0,1,4,30,0,0, 1,0, {8'd0,8'd6,8'd6,8'd6}, {16'd0,16'd12,16'd11,16'd10}, 4'b0111, 4'd3);
    add(0,0,0,0,0,1, 1,1, {8'd0,8'd0,8'd0,8'd4}, {16'd0,16'd0,16'd0,16'd30}, 4'b0001, 4'd1);
    // clear alone, then clear with a same-cycle sample
    add(0,1,100,0,0,0, 0,0, 0,0,0,0);
    add(0,0,0,0,1,0, 0,0, 0,0,0,0);
    add(0,1,1,1,0,1, 1,1, {8'd0,8'd0,8'd0,8'd1}, {16'd0,16'd0,16'd0,16'd1}, 4'b0001, 4'd1);
    add(0,1,100,0,0,0, 0,0, 0,0,0,0);
    add(0,1,50,2,1,0, 0,0, 0,0,0,0);
    add(0,0,0,0,0,1, 1,1, {8'd0,8'd0,8'd0,8'd50}, {16'd0,16'd0,16'd0,16'd2}, 4'b0001, 4'd1);
    // reset mid-frame, reset beating last, then an empty frame
    add(0,1,7,1,0,0, 0,0, 0,0,0,0);
    add(0,1,8,2,0,0, 0,0, 0,0,0,0);
    add(0,1,9,3,0,0, 0,0, 0,0,0,0);
    add(1,1,10,4,0,0, 1,0, 0,0,0,0);
    add(1,1,11,5,0,1, 1,0, 0,0,0,0);
    add(0,0,0,0,0,1, 1,1, 0,0,4'b0000,4'd0);
    // signedness
    add(0,1,8'hFF,0,0,0, 0,0, 0,0,0,0);
`ifdef TOPK_SIGNED_EN
    add(0,1,8'h01,1,0,1, 1,1, {8'd0,8'd0,8'hFF,8'h01}, {16'd0,16'd0,16'd0,16'd1}, 4'b0011, 4'd2);
`else
    add(0,1,8'h01,1,0,1, 1,1, {8'd0,8'd0,8'h01,8'hFF}, {16'd0,16'd0,16'd1,16'd0}, 4'b0011, 4'd2);
`endif

    foreach (tbl[n]) begin
      rst = tbl[n].r; enable = tbl[n].e; stream = tbl[n].s; index = tbl[n].ix;
      clear = tbl[n].c; last = tbl[n].l;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done", n), 64'(done), 64'(tbl[n].d));
      if (tbl[n].k) begin
        chk($sformatf("v%0d_value", n), 64'(topk_value),   64'(tbl[n].ev));
        chk($sformatf("v%0d_index", n), 64'(topk_index),   64'(tbl[n].ei));
        chk($sformatf("v%0d_valid", n), 64'(topk_valid),   64'(tbl[n].evl));
        chk($sformatf("v%0d_count", n), 64'(sample_count), 64'(tbl[n].ec));
      end
    end

    // counter saturation: 20 samples in one frame
    rstep(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 20; n++)
      rstep(0, 1, 8'($urandom_range(0, 255)), 16'(n), 0, (n == 19));
    chk("sat_count", 64'(sample_count), 64'(4'd15));
    chk("sat_valid", 64'(topk_valid), 64'(4'b1111));

    // random traffic with heavy value collisions
    rstep(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] s;
      s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      rstep(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70), s, 16'(n),
            ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 10));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_topk_val
`default_nettype wire

// File: doc/topk_val.md
Name: topk_val

Overview:
- Streaming top-K tracker; parametrised successor of the single-maximum tracker on the CISR accumulator output.
- Watches the (write, row address, accumulated data) stream leaving cisr_acc.
- Keeps the K largest row results of a frame, sorted descending with their row indices.
- Publishes a registered snapshot plus a done pulse at end of frame.
- Feeds the result-readout logic that replaces the single max_index output.

Parameters:
- K, 4, number of ranks tracked (>=1).
- DATA_W, 32, width of the accumulated value (matches accumulator_size).
- IDX_W, 16, width of the row index (matches row_id_size).
- CNT_W, 32, width of the per-frame sample counter (saturating).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset; all state sampled on the rising edge of clk
- enable  in  1  sample valid (driven by cisr write strobe)
- stream  in  DATA_W  sample value
- index  in  IDX_W  sample row index
- clear  in  1  discard the working frame
- last  in  1  end of frame; may coincide with enable
- topk_value  out  K*DATA_W  snapshot values; rank r at [r*DATA_W +: DATA_W], rank 0 largest
- topk_index  out  K*IDX_W  snapshot indices, same layout
- topk_valid  out  K  snapshot rank-valid bits; bit r = rank r
- sample_count  out  CNT_W  samples accepted in the snapshotted frame
- done  out  1  one-cycle pulse: snapshot updated

Behaviour:
- Working array W[0..K-1] = {value, index, valid}:
  - kept sorted descending;
  - valid entries are contiguous from rank 0.
- Insertion on enable:
  - p = number of valid entries with value >= stream.
  - If p<K: entries p..K-2 shift to p+1..K-1, the old K-1 entry is dropped, and the sample is written at p.
  - If p==K: sample discarded.
  - One compare stage; the sample is visible in W the next cycle.
- Ties: a new sample ranks below existing equal values (earlier arrival wins). Indices are never compared.
- Comparison is unsigned by default.
- Working counter: increments on each enable and saturates at all-ones. Dropped samples still count.
- clear:
  - Next W = all invalid; counter = 0.
  - With clear and enable in the same cycle, the sample survives: next W = sample at rank 0 only, counter = 1.
- last:
  - Snapshot outputs are loaded with W_next and counter_next, i.e. including any same-cycle enable, after applying clear if also asserted.
  - done = 1 the following cycle for exactly one cycle.
  - W and counter are then reset to empty.
  - enable in the cycle after last belongs to the new frame.
  - last with an empty frame yields all-invalid ranks and count 0, and still pulses done.
- Snapshot outputs hold their values until the next last or rst.
- Invalid ranks in the snapshot output value 0 and index 0.
- Reset: W all invalid, counter 0, topk_value/topk_index/topk_valid/sample_count all 0, done 0.
  - Reset overrides enable, clear and last in the same cycle.
  - Reset mid-frame loses the frame silently, with no done pulse.
- No backpressure: one sample per cycle is sustained indefinitely.

Optional Feature:
- Macro TOPK_SIGNED_EN.
- Defined: stream and stored values are compared as two's-complement DATA_W-bit signed numbers.
- Undefined: unsigned compare.
- All other behaviour is identical.

Decomposition:
- Package topk_pkg holds:
  - default widths (DATA_W, IDX_W, CNT_W);
  - the rank-entry struct typedef {value, index, valid};
  - the compare function, with signedness selected by TOPK_SIGNED_EN.
- One natural sub-module, topk_slot, instantiated K times. Each slot:
  - holds one rank register;
  - computes its ">= stream" flag;
  - selects hold, shift-in from rank r-1, or load sample, from its own flag and its neighbour's flag.

Test Plan:
- K=4, unsigned; stream 5,9,1,7,3 with index 0..4 on consecutive cycles, last with the 5th sample -> one cycle later done=1; values 9,7,5,3; indices 1,3,0,4; valid 4'b1111; count 5.
- Two samples 2 (idx 20) and 8 (idx 21), last on the second -> values 8,2,0,0; indices 21,20,0,0; valid 4'b0011; count 2.
- Ties: 6,6,6 at idx 10,11,12, last -> ranks 0..2 = idx 10,11,12. Then back-to-back frame: enable 4 (idx 30) in the cycle after last, then last -> rank0 = 4/idx 30, count 1.
- Clear mid-frame: 100 idx 0; clear alone; then 1 idx 1 with last -> rank0 = 1/idx 1, valid 4'b0001, count 1. Repeat with clear+enable(50, idx 2) in the same cycle -> rank0 = 50/idx 2.
- Reset mid-frame: three samples, then rst with enable high; then last alone -> done pulses, all outputs 0, count 0. No done pulse during reset.
- TOPK_SIGNED_EN, DATA_W=8; samples 0xFF (idx 0), 0x01 (idx 1), last -> rank0 = 0x01/idx 1. Same stimulus without the macro -> rank0 = 0xFF/idx 0.
